// File: rtl/resync_cmd_decoder.sv
// rtl/resync_cmd_decoder.sv - ReSync serial command deframer driving ADC/DTU reset, cal and control strobes
module resync_cmd_decoder #(
  parameter int N_ADC    = 2,
  parameter int CMD_W    = 4,
  parameter int TP_LEN_W = 8,
  parameter int RST_LEN  = 8,
  parameter int CAL_LEN  = 4
) (
  input  logic                clock,
  input  logic                rst_b,
  input  logic                serial_in,
  input  logic [N_ADC-1:0]    adc_mask,
  input  logic [N_ADC-1:0]    AdcCalBusyIn,
  input  logic [TP_LEN_W-1:0] TP_len,
  output logic [N_ADC-1:0]    AdcRst_b,
  output logic [N_ADC-1:0]    AdcCal,
  output logic                DtuRst_b,
  output logic                i2cRst_b,
  output logic                atuRst_b,
  output logic                DtuSyncMode,
  output logic                DtuFlush,
  output logic                BC0mark,
  output logic                PllLockStart,
  output logic                CatiaTP,
  output logic                cmd_valid,
  output logic                cmd_err
);

  localparam int RW = $clog2(RST_LEN + 1);
  localparam int CW = $clog2(CAL_LEN + 1);
  localparam int BW = (CMD_W > 1) ? $clog2(CMD_W) : 1;

  typedef enum logic [1:0] {IDLE, CMD, PAR} state_t;

  state_t            state, nextState;
  logic [CMD_W-1:0]  cmdSr;
  logic [BW-1:0]     bitCnt;
  logic              inPar, parOk, known, doCmd;
  logic [11:1]       hit;

  logic [RW-1:0]       adcRstCnt [N_ADC];
  logic [CW-1:0]       adcCalCnt [N_ADC];
  logic [RW-1:0]       dtuCnt, i2cCnt, atuCnt;
  logic [TP_LEN_W-1:0] tpCnt;

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (serial_in) nextState = CMD;
      CMD:     if (bitCnt == BW'(CMD_W - 1)) nextState = PAR;
      PAR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      cmdSr  <= '0;
      bitCnt <= '0;
    end else if (state == CMD) begin
      cmdSr  <= {cmdSr[CMD_W-2:0], serial_in};
      bitCnt <= bitCnt + BW'(1);
    end else begin
      bitCnt <= '0;
    end
  end

  // The parity bit is the live serial_in during PAR; the command is fully shifted by then.
  always_comb begin
    inPar = (state == PAR);
    parOk = ~(^cmdSr ^ serial_in);
    known = (cmdSr <= CMD_W'(11));
    doCmd = inPar && parOk && known;
    hit   = '0;
    for (int c = 1; c <= 11; c++) hit[c] = doCmd && (cmdSr == CMD_W'(c));
  end

  function automatic logic [RW-1:0] stepRst(input logic load, input logic [RW-1:0] cnt);
    if (load)             return RW'(RST_LEN);
    else if (cnt != '0)   return cnt - RW'(1);
    else                  return cnt;
  endfunction

  function automatic logic [CW-1:0] stepCal(input logic load, input logic [CW-1:0] cnt);
    if (load)             return CW'(CAL_LEN);
    else if (cnt != '0)   return cnt - CW'(1);
    else                  return cnt;
  endfunction

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < N_ADC; i++) begin
        adcRstCnt[i] <= '0;
        adcCalCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ADC; i++) begin
        adcRstCnt[i] <= stepRst(hit[1] && adc_mask[i], adcRstCnt[i]);
        // Busy channels are skipped; an already-running cal pulse keeps counting down.
        adcCalCnt[i] <= stepCal(hit[2] && adc_mask[i] && !AdcCalBusyIn[i], adcCalCnt[i]);
      end
    end
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      dtuCnt <= '0;
      i2cCnt <= '0;
      atuCnt <= '0;
      tpCnt  <= '0;
    end else begin
      dtuCnt <= stepRst(hit[3], dtuCnt);
      i2cCnt <= stepRst(hit[4], i2cCnt);
      atuCnt <= stepRst(hit[5], atuCnt);
      // Reloading with TP_len=0 ends any running pulse.
      if (hit[10])           tpCnt <= TP_len;
      else if (tpCnt != '0)  tpCnt <= tpCnt - TP_LEN_W'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      DtuSyncMode  <= 1'b0;
      DtuFlush     <= 1'b0;
      BC0mark      <= 1'b0;
      PllLockStart <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      if (hit[6])      DtuSyncMode <= 1'b1;
      else if (hit[7]) DtuSyncMode <= 1'b0;
      DtuFlush     <= hit[8];
      BC0mark      <= hit[9];
      PllLockStart <= hit[11];
      cmd_valid    <= doCmd;
      cmd_err      <= inPar && !(parOk && known);
    end
  end

  always_comb begin
    for (int i = 0; i < N_ADC; i++) begin
      AdcRst_b[i] = (adcRstCnt[i] == '0);
      AdcCal[i]   = (adcCalCnt[i] != '0);
    end
    DtuRst_b = (dtuCnt == '0);
    i2cRst_b = (i2cCnt == '0);
    atuRst_b = (atuCnt == '0);
    CatiaTP  = (tpCnt != '0);
  end

endmodule
